// File: rtl/display_source_arbiter_if.sv
// Display RAM write-port bundle: FFT and lock-in sample streams in,
// RAM write strobe/address/data out.
interface display_source_arbiter_if #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 24,
    parameter int LOCKIN_W = 42
);
    logic [ADDR_W-1:0]   fft_addr;
    logic [DATA_W-1:0]   fft_mag;
    logic                fft_valid;
    logic                lockin_valid;
    logic [LOCKIN_W-1:0] lockin_mag;
    logic [LOCKIN_W-1:0] lockin_phs;
    logic                o_wr_en;
    logic [ADDR_W-1:0]   o_wr_addr;
    logic [DATA_W-1:0]   o_wr_data;

    modport master (
        input  fft_addr, fft_mag, fft_valid,
        input  lockin_valid, lockin_mag, lockin_phs,
        output o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        output fft_addr, fft_mag, fft_valid,
        output lockin_valid, lockin_mag, lockin_phs,
        input  o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/display_source_arbiter.sv
// Arbitrates the display RAM write port between FFT and lock-in streams.
// DISPLAY_CLEAR_ON_RESET_EN: start a full RAM clear straight out of reset.
module display_source_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 24,
    parameter int LOCKIN_W     = 42,
    parameter int LOCKIN_SHIFT = 18
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_switch_mode,
    input  logic                      i_frame_start,
    display_source_arbiter_if.master  bus,
    output logic                      o_mode,
    output logic                      o_busy,
    output logic                      o_overrun
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LK_PHS,
        CLEAR
    } state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_phs;
    logic                r_pend;
    logic [LOCKIN_W-1:0] r_pend_mag;
    logic [LOCKIN_W-1:0] r_pend_phs;

    wire                w_change    = (r_sync2 != o_mode);
    wire                w_any_valid = bus.fft_valid | bus.lockin_valid;
    wire [LOCKIN_W-1:0] w_mag = bus.lockin_valid ? bus.lockin_mag : r_pend_mag;
    wire [LOCKIN_W-1:0] w_phs = bus.lockin_valid ? bus.lockin_phs : r_pend_phs;

    function automatic logic [DATA_W-1:0] sat(input logic [LOCKIN_W-1:0] x);
        logic [LOCKIN_W-1:0] y;
        y = x >> LOCKIN_SHIFT;
        if ((y >> DATA_W) != '0)
            sat = '1;
        else
            sat = y[DATA_W-1:0];
    endfunction

    assign bus.o_wr_en   = r_wr_en;
    assign bus.o_wr_addr = r_wr_addr;
    assign bus.o_wr_data = r_wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cnt      <= '0;
            r_phs      <= '0;
            r_pend     <= 1'b0;
            r_pend_mag <= '0;
            r_pend_phs <= '0;
            o_mode     <= 1'b0;
            o_overrun  <= 1'b0;
`ifdef DISPLAY_CLEAR_ON_RESET_EN
            r_state    <= CLEAR;
            o_busy     <= 1'b1;
`else
            r_state    <= IDLE;
            o_busy     <= 1'b0;
`endif
        end else begin
            r_sync1   <= i_switch_mode;
            r_sync2   <= r_sync1;
            r_wr_en   <= 1'b0;
            o_overrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    o_busy <= 1'b0;
                    if (i_frame_start && w_change) begin
                        o_mode    <= r_sync2;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= '0;
                        r_wr_data <= '0;
                        r_cnt     <= ADDR_W'(1);
                        o_busy    <= 1'b1;
                        o_overrun <= w_any_valid;
                        r_pend    <= 1'b0;
                        r_state   <= CLEAR;
                    end else if (o_mode && bus.fft_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= bus.fft_addr;
                        r_wr_data <= bus.fft_mag;
                    end else if (!o_mode && (bus.lockin_valid || r_pend)) begin
                        // live sample wins; the older pending one is dropped
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= '0;
                        r_wr_data <= sat(w_mag);
                        r_phs     <= sat(w_phs);
                        r_pend    <= 1'b0;
                        r_state   <= LK_PHS;
                    end
                end
                LK_PHS: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= ADDR_W'(1);
                    r_wr_data <= r_phs;
                    r_state   <= IDLE;
                    if (bus.lockin_valid) begin
                        r_pend     <= 1'b1;
                        r_pend_mag <= bus.lockin_mag;
                        r_pend_phs <= bus.lockin_phs;
                        o_overrun  <= r_pend;
                    end
                end
                CLEAR: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_cnt;
                    r_wr_data <= '0;
                    r_cnt     <= r_cnt + ADDR_W'(1);
                    o_overrun <= w_any_valid;
                    if (r_cnt == LAST)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
